ucsbece154a_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single unified instruction/data memory between the multicycle core's memory port (port 0) and a debug/program-loader port (port 1). Each port issues one word access at a time over a req/done handshake. The arbiter serialises the accesses with round-robin priority, drives the memory's single port, and absorbs the memory's fixed read latency. It sits between the core's memory interface and the memory macro.

---
 rtl/ucsbece154a_mem_arbiter_if.sv | 43 ++++
 rtl/ucsbece154a_mem_arbiter.sv | 93 +++++++++
 tb/tb_ucsbece154a_mem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ucsbece154a_mem_arbiter_if.sv
// rtl/ucsbece154a_mem_arbiter_if.sv - port bundle between two requesters, the arbiter and the memory macro
interface ucsbece154a_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              p0_req_i;
  logic              p0_we_i;
  logic [ADDR_W-1:0] p0_addr_i;
  logic [DATA_W-1:0] p0_wdata_i;
  logic              p0_gnt_o;
  logic              p0_done_o;

  logic              p1_req_i;
  logic              p1_we_i;
  logic [ADDR_W-1:0] p1_addr_i;
  logic [DATA_W-1:0] p1_wdata_i;
  logic              p1_gnt_o;
  logic              p1_done_o;

  logic [DATA_W-1:0] rdata_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i,
    input  p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i,
    input  mem_rdata_i,
    output p0_gnt_o, p0_done_o, p1_gnt_o, p1_done_o, rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i,
    output p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i,
    output mem_rdata_i,
    input  p0_gnt_o, p0_done_o, p1_gnt_o, p1_done_o, rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/ucsbece154a_mem_arbiter.sv
// rtl/ucsbece154a_mem_arbiter.sv - round-robin two-port arbiter in front of a single-port fixed-latency memory
module ucsbece154a_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  ucsbece154a_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  state_t            state_q, state_d;
  logic              last_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [2:0]        cnt_q;

  logic win;
  logic take;
  logic cap;
  logic access;
  logic busy;

  // Requests are only looked at in IDLE; last_q doubles as the current owner.
  always_comb begin
    state_d = state_q;
    win     = last_q;
    take    = 1'b0;
    cap     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.p0_req_i || bus.p1_req_i) begin
          take    = 1'b1;
          state_d = ACCESS;
          if (bus.p0_req_i && bus.p1_req_i) win = ~last_q;
          else                              win = bus.p1_req_i;
        end
      end
      ACCESS: state_d = we_q ? DONE : WAIT;
      WAIT: begin
        if (cnt_q == 3'd1) begin
          cap     = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      if (take) begin
        last_q  <= win;
        we_q    <= win ? bus.p1_we_i    : bus.p0_we_i;
        addr_q  <= win ? bus.p1_addr_i  : bus.p0_addr_i;
        wdata_q <= win ? bus.p1_wdata_i : bus.p0_wdata_i;
      end
      if (state_q == ACCESS && !we_q) cnt_q <= LAT;
      else if (state_q == WAIT)       cnt_q <= cnt_q - 3'd1;
      if (cap) rdata_q <= bus.mem_rdata_i;
    end
  end

  // Memory-side fields are forced to zero outside the single ACCESS cycle.
  assign access = (state_q == ACCESS);
  assign busy   = (state_q != IDLE);

  assign bus.mem_en_o    = access;
  assign bus.mem_we_o    = access & we_q;
  assign bus.mem_addr_o  = access ? addr_q  : '0;
  assign bus.mem_wdata_o = access ? wdata_q : '0;

  assign bus.p0_gnt_o  = busy & ~last_q;
  assign bus.p1_gnt_o  = busy &  last_q;
  assign bus.p0_done_o = (state_q == DONE) & ~last_q;
  assign bus.p1_done_o = (state_q == DONE) &  last_q;
  assign bus.rdata_o   = rdata_q;
endmodule

// File: tb/tb_ucsbece154a_mem_arbiter.sv
// tb/tb_ucsbece154a_mem_arbiter.sv - directed scoreboard bench for the two-port memory arbiter
module tb_ucsbece154a_mem_arbiter;
  localparam int L_MAIN = 2;
  localparam int L_1    = 1;
  localparam int L_4    = 4;
  localparam int L_7    = 7;
  localparam int LAT [4] = '{L_MAIN, L_1, L_4, L_7};

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ucsbece154a_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b2 ();
  ucsbece154a_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  ucsbece154a_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b4 ();
  ucsbece154a_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b7 ();

  ucsbece154a_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(L_MAIN)) dut    (.clk(clk), .reset(reset), .bus(b2));
  ucsbece154a_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(L_1))    dut_l1 (.clk(clk), .reset(reset), .bus(b1));
  ucsbece154a_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(L_4))    dut_l4 (.clk(clk), .reset(reset), .bus(b4));
  ucsbece154a_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(L_7))    dut_l7 (.clk(clk), .reset(reset), .bus(b7));

  // Latency-sweep instances only ever see a p1 read request.
  logic [3:1]  sreq = 3'b000;
  logic [31:0] s_addr = 32'd0;
  logic [3:1]  s_done, s_gnt, s_p0;
  logic [31:0] s_rdata [1:3];

  logic        en_a    [4];
  logic        we_a    [4];
  logic [31:0] addr_a  [4];
  logic [31:0] wdata_a [4];
  logic [31:0] rd_a    [4];

  assign en_a[0] = b2.mem_en_o;  assign we_a[0] = b2.mem_we_o;  assign addr_a[0] = b2.mem_addr_o;  assign wdata_a[0] = b2.mem_wdata_o;
  assign en_a[1] = b1.mem_en_o;  assign we_a[1] = b1.mem_we_o;  assign addr_a[1] = b1.mem_addr_o;  assign wdata_a[1] = b1.mem_wdata_o;
  assign en_a[2] = b4.mem_en_o;  assign we_a[2] = b4.mem_we_o;  assign addr_a[2] = b4.mem_addr_o;  assign wdata_a[2] = b4.mem_wdata_o;
  assign en_a[3] = b7.mem_en_o;  assign we_a[3] = b7.mem_we_o;  assign addr_a[3] = b7.mem_addr_o;  assign wdata_a[3] = b7.mem_wdata_o;
  assign b2.mem_rdata_i = rd_a[0];
  assign b1.mem_rdata_i = rd_a[1];
  assign b4.mem_rdata_i = rd_a[2];
  assign b7.mem_rdata_i = rd_a[3];

  assign b1.p0_req_i = 1'b0; assign b1.p0_we_i = 1'b0; assign b1.p0_addr_i = 32'd0; assign b1.p0_wdata_i = 32'd0;
  assign b4.p0_req_i = 1'b0; assign b4.p0_we_i = 1'b0; assign b4.p0_addr_i = 32'd0; assign b4.p0_wdata_i = 32'd0;
  assign b7.p0_req_i = 1'b0; assign b7.p0_we_i = 1'b0; assign b7.p0_addr_i = 32'd0; assign b7.p0_wdata_i = 32'd0;
  assign b1.p1_req_i = sreq[1]; assign b1.p1_we_i = 1'b0; assign b1.p1_addr_i = s_addr; assign b1.p1_wdata_i = 32'd0;
  assign b4.p1_req_i = sreq[2]; assign b4.p1_we_i = 1'b0; assign b4.p1_addr_i = s_addr; assign b4.p1_wdata_i = 32'd0;
  assign b7.p1_req_i = sreq[3]; assign b7.p1_we_i = 1'b0; assign b7.p1_addr_i = s_addr; assign b7.p1_wdata_i = 32'd0;
  assign s_done  = {b7.p1_done_o, b4.p1_done_o, b1.p1_done_o};
  assign s_gnt   = {b7.p1_gnt_o,  b4.p1_gnt_o,  b1.p1_gnt_o};
  assign s_p0    = {b7.p0_gnt_o | b7.p0_done_o, b4.p0_gnt_o | b4.p0_done_o, b1.p0_gnt_o | b1.p0_done_o};
  assign s_rdata[1] = b1.rdata_o;
  assign s_rdata[2] = b4.rdata_o;
  assign s_rdata[3] = b7.rdata_o;

  // Memory model: unwritten words hold a fixed pattern, read data is valid only in the latency cycle.
  logic [31:0] mem [256];
  bit [255:0]  written;
  bit          pv [4][7];
  logic [31:0] pd [4][7];

  function automatic logic [31:0] init_word(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEAD_BEEF : {8'hC0, a, ~a, 8'h5A};
  endfunction

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return written[a] ? mem[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (en_a[k] && we_a[k]) begin
        mem[addr_a[k][7:0]]     <= wdata_a[k];
        written[addr_a[k][7:0]] <= 1'b1;
      end
      pv[k][0] <= en_a[k] && !we_a[k];
      pd[k][0] <= mem_word(addr_a[k][7:0]);
      for (int s = 1; s < 7; s++) begin
        pv[k][s] <= pv[k][s-1];
        pd[k][s] <= pd[k][s-1];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rd_a[k] = pv[k][LAT[k]-1] ? pd[k][LAT[k]-1] : (32'hBAD0_0000 | 32'(k));
    end
  end

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          strobe_cyc = 0;
  int          n_done = 0;
  int          n_we = 0;
  bit          strobed = 1'b0;
  logic [31:0] exp_rdata = 32'd0;
  txn_t        exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obsv, input logic [31:0] expv);
    n_chk++;
    assert (obsv === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obsv, expv);
    end
  endtask

  task automatic push(input logic port, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata);
    txn_t t;
    t.port = port; t.we = we; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
    exp_q.push_back(t);
  endtask

  // One cycle forward, then the main-instance monitor against the scoreboard.
  task automatic step();
    txn_t t;
    @(negedge clk);
    cyc++;
    chk("gnt_overlap", 32'(b2.p0_gnt_o & b2.p1_gnt_o), 32'd0);
    if (!b2.mem_en_o) begin
      chk("bus_quiet", 32'(b2.mem_we_o) | b2.mem_addr_o | b2.mem_wdata_o, 32'd0);
    end else begin
      if (b2.mem_we_o) n_we++;
      if (strobed || exp_q.size() == 0) begin
        chk("dup_strobe", 32'(b2.mem_en_o), 32'd0);
      end else begin
        t = exp_q[0];
        chk("strobe_we", 32'(b2.mem_we_o), 32'(t.we));
        chk("strobe_addr", b2.mem_addr_o, t.addr);
        if (t.we) chk("strobe_wdata", b2.mem_wdata_o, t.wdata);
        strobed    = 1'b1;
        strobe_cyc = cyc;
      end
    end
    if (strobed) chk("gnt_owner", 32'({b2.p1_gnt_o, b2.p0_gnt_o}), exp_q[0].port ? 32'd2 : 32'd1);
    else         chk("gnt_idle",  32'({b2.p1_gnt_o, b2.p0_gnt_o}), 32'd0);
    if (b2.p0_done_o || b2.p1_done_o) begin
      if (!strobed) begin
        chk("unexp_done", 32'({b2.p1_done_o, b2.p0_done_o}), 32'd0);
      end else begin
        t = exp_q.pop_front();
        chk("done_port", 32'({b2.p1_done_o, b2.p0_done_o}), t.port ? 32'd2 : 32'd1);
        chk("done_lat", 32'(cyc - strobe_cyc), t.we ? 32'd1 : 32'(1 + L_MAIN));
        if (!t.we) exp_rdata = t.rdata;
        strobed = 1'b0;
        n_done++;
      end
    end
    chk("rdata", b2.rdata_o, exp_rdata);
  endtask

  task automatic run_txns(input int budget, input string tag);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() > 0) begin
      chk({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      strobed = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b1;
    exp_q.delete();
    strobed   = 1'b0;
    exp_rdata = 32'd0;
    repeat (n) step();
    reset = 1'b0;
  endtask

  task automatic sweep_read(input logic [31:0] a, input logic [3:1] mask);
    int c0;
    bit [3:1] seen = 3'b000;
    logic [31:0] want;
    want   = mem_word(a[7:0]);
    s_addr = a;
    sreq   = mask;
    c0     = cyc;
    for (int n = 0; n < 14; n++) begin
      step();
      chk("sw_p0_idle", 32'(s_p0), 32'd0);
      for (int k = 1; k <= 3; k++) begin
        if (sreq[k] && s_done[k]) begin
          chk("sw_done_cyc", 32'(cyc - c0), 32'(2 + LAT[k]));
          chk("sw_rdata", s_rdata[k], want);
          chk("sw_gnt", 32'(s_gnt[k]), 32'd1);
          sreq[k] = 1'b0;
          seen[k] = 1'b1;
        end
      end
    end
    chk("sw_all_done", 32'(seen), 32'(mask));
    sreq = 3'b000;
  endtask

  int c0;
  int prev_strobe;
  int base;

  initial begin
    b2.p0_req_i = 1'b0; b2.p0_we_i = 1'b0; b2.p0_addr_i = 32'd0; b2.p0_wdata_i = 32'd0;
    b2.p1_req_i = 1'b0; b2.p1_we_i = 1'b0; b2.p1_addr_i = 32'd0; b2.p1_wdata_i = 32'd0;

    do_reset(2);
    chk("rst_gnt",   32'({b2.p1_gnt_o, b2.p0_gnt_o}), 32'd0);
    chk("rst_done",  32'({b2.p1_done_o, b2.p0_done_o}), 32'd0);
    chk("rst_mem",   32'({b2.mem_en_o, b2.mem_we_o}), 32'd0);
    chk("rst_addr",  b2.mem_addr_o, 32'd0);
    chk("rst_rdata", b2.rdata_o, 32'd0);
    step();

    // Single read by p0 at word 0x10.
    b2.p0_req_i = 1'b1; b2.p0_we_i = 1'b0; b2.p0_addr_i = 32'h10;
    push(1'b0, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF);
    c0 = cyc;
    step();
    chk("t1_strobe", 32'({b2.mem_en_o, b2.mem_we_o}), 32'd2);
    run_txns(12, "t1");
    chk("t1_done_cyc", 32'(cyc - c0), 32'd4);
    chk("t1_rdata", b2.rdata_o, 32'hDEAD_BEEF);
    b2.p0_req_i = 1'b0;
    step();

    // Single write by p1; rdata must keep the previous read.
    base = n_we;
    b2.p1_req_i = 1'b1; b2.p1_we_i = 1'b1; b2.p1_addr_i = 32'h20; b2.p1_wdata_i = 32'h0000_1234;
    push(1'b1, 1'b1, 32'h20, 32'h0000_1234, 32'd0);
    c0 = cyc;
    run_txns(8, "t2");
    chk("t2_done_cyc", 32'(cyc - c0), 32'd2);
    b2.p1_req_i = 1'b0; b2.p1_we_i = 1'b0;
    step();
    chk("t2_we_pulses", 32'(n_we - base), 32'd1);
    chk("t2_landed", mem_word(8'h20), 32'h0000_1234);
    chk("t2_rdata_kept", b2.rdata_o, 32'hDEAD_BEEF);

    // Contention from reset: both ports hold reads, grants must alternate p0, p1, p0, p1.
    do_reset(1);
    base = n_done;
    b2.p0_req_i = 1'b1; b2.p0_we_i = 1'b0; b2.p0_addr_i = 32'h30;
    b2.p1_req_i = 1'b1; b2.p1_we_i = 1'b0; b2.p1_addr_i = 32'h40;
    for (int i = 0; i < 2; i++) begin
      push(1'b0, 1'b0, 32'h30, 32'd0, init_word(8'h30));
      push(1'b1, 1'b0, 32'h40, 32'd0, init_word(8'h40));
    end
    run_txns(40, "t3");
    b2.p0_req_i = 1'b0; b2.p1_req_i = 1'b0;
    chk("t3_done_count", 32'(n_done - base), 32'd4);
    repeat (3) step();

    // Back-to-back writes by p0, req re-raised the cycle after each done.
    base = n_we;
    prev_strobe = 0;
    for (int i = 0; i < 3; i++) begin
      b2.p0_req_i = 1'b1; b2.p0_we_i = 1'b1;
      b2.p0_addr_i = 32'h50 + 32'(i); b2.p0_wdata_i = 32'hA0 + 32'(i);
      push(1'b0, 1'b1, 32'h50 + 32'(i), 32'hA0 + 32'(i), 32'd0);
      run_txns(8, "t4");
      if (i > 0) chk("t4_spacing", 32'(strobe_cyc - prev_strobe), 32'd3);
      prev_strobe = strobe_cyc;
      b2.p0_req_i = 1'b0;
      step();
    end
    chk("t4_we_pulses", 32'(n_we - base), 32'd3);
    for (int i = 0; i < 3; i++) chk("t4_landed", mem_word(8'h50 + 8'(i)), 32'hA0 + 32'(i));
    b2.p0_req_i = 1'b1; b2.p0_we_i = 1'b0; b2.p0_addr_i = 32'h51;
    push(1'b0, 1'b0, 32'h51, 32'd0, 32'h0000_00A1);
    run_txns(12, "t4rd");
    b2.p0_req_i = 1'b0;
    step();

    // Latency sweep on the 1/4/7-cycle instances.
    sweep_read(32'h10, 3'b111);
    step();
    sweep_read(32'h60, 3'b111);
    step();

    // Reset during WAIT on the 4-cycle instance.
    s_addr = 32'h70; sreq = 3'b010;
    c0 = cyc;
    repeat (3) step();
    reset = 1'b1; sreq = 3'b000; exp_rdata = 32'd0;
    step();
    reset = 1'b0;
    chk("t5_gnt",   32'({s_gnt[2], s_p0[2]}), 32'd0);
    chk("t5_done",  32'(s_done[2]), 32'd0);
    chk("t5_mem",   32'({en_a[2], we_a[2]}), 32'd0);
    chk("t5_addr",  addr_a[2] | wdata_a[2], 32'd0);
    chk("t5_rdata", s_rdata[2], 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t5_quiet", 32'({s_done[2], en_a[2]}), 32'd0);
    end
    sweep_read(32'h60, 3'b010);
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
